// File: rtl/glyph_loader.sv
// Glyph RAM writer: unpacks framed 16x16 RGB glyph images from a byte stream into pixel writes.
// Optional trailing checksum byte enabled by defining GLYPH_LOADER_CKSUM_EN.
module glyph_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned PIX_LOG2  = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdxW = ADDR_W - PIX_LOG2;

  typedef enum logic [2:0] {StIdle, StIndex, StPixel, StCksum, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     index_q, index_d;
  logic [PIX_LOG2-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          r_q, r_d, g_q, g_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [23:0]         wr_data_q, wr_data_d;
  logic                accept;

  assign in_ready = (state_q != StDone);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    pix_cnt_d  = pix_cnt_q;
    byte_cnt_d = byte_cnt_q;
    r_d        = r_q;
    g_d        = g_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d    = StIndex;
          pix_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      StIndex: begin
        if (accept) begin
          // Index bits beyond the glyph field are dropped, not range-checked.
          index_d = IdxW'(in_data);
          state_d = StPixel;
        end
      end
      StPixel: begin
        if (accept) begin
          unique case (byte_cnt_q)
            2'd0: begin
              r_d        = in_data;
              byte_cnt_d = 2'd1;
            end
            2'd1: begin
              g_d        = in_data;
              byte_cnt_d = 2'd2;
            end
            default: begin
              byte_cnt_d = 2'd0;
              wr_en_d    = 1'b1;
              wr_addr_d  = {index_q, pix_cnt_q};
              wr_data_d  = {r_q, g_q, in_data};
              pix_cnt_d  = pix_cnt_q + 1'b1;
              if (pix_cnt_q == '1) begin
`ifdef GLYPH_LOADER_CKSUM_EN
                state_d = StCksum;
`else
                state_d = StDone;
`endif
              end
            end
          endcase
        end
      end
      StCksum: begin
        if (accept) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      index_q    <= '0;
      pix_cnt_q  <= '0;
      byte_cnt_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      pix_cnt_q  <= pix_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      r_q        <= r_d;
      g_q        <= g_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

`ifdef GLYPH_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  // Sum covers index and pixel bytes; the trailing byte must bring it to zero.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == SYNC_BYTE) begin
            sum_d = '0;
            err_d = 1'b0;
          end
        end
        StIndex, StPixel: sum_d = sum_q + in_data;
        StCksum: begin
          if ((sum_q + in_data) != 8'h00) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone) && !err;

endmodule

// File: tb/tb_glyph_loader.sv
// Directed-random bench for glyph_loader: frames are built from random pixels and the expected
// write stream is derived per pixel as addr = {index, pixel}, data = {R,G,B}.
module tb_glyph_loader;

  localparam int unsigned Pix = 256;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int          checks;
  int          errors;
  logic [15:0] last_addr;
  logic [23:0] last_data;
  logic [23:0] frame_pix [Pix];

  glyph_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Presents one byte (after optional random idle cycles) and checks the cycle after acceptance.
  task automatic step_byte(input logic [7:0] b, input int gap_pct, input bit exp_wr,
                           input logic [15:0] ea, input logic [23:0] ed);
    int guard;
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_wr_en", wr_en, 0);
      chk("gap_hold_addr", wr_addr, last_addr);
      chk("gap_hold_data", wr_data, last_data);
    end
    guard = 0;
    while (!in_ready && guard < 8) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", wr_addr, ea);
      chk("wr_data", wr_data, ed);
      last_addr = ea;
      last_data = ed;
    end else begin
      chk("hold_addr", wr_addr, last_addr);
    end
  endtask

  task automatic send_frame(input logic [7:0] idx, input int gap_pct, input bit bad_ck);
    logic [7:0] sum;
    logic [7:0] b;
    bit         ok;
    step_byte(8'hA5, gap_pct, 1'b0, 16'h0, 24'h0);
    chk("busy_after_sync", busy, 1);
    chk("err_after_sync", err, 0);
    step_byte(idx, gap_pct, 1'b0, 16'h0, 24'h0);
    sum = idx;
    for (int p = 0; p < Pix; p++) begin
      for (int k = 0; k < 3; k++) begin
        b   = frame_pix[p][23 - 8 * k -: 8];
        sum = sum + b;
        step_byte(b, gap_pct, (k == 2), {idx, 8'(p)}, frame_pix[p]);
      end
    end
    ok = 1'b1;
`ifdef GLYPH_LOADER_CKSUM_EN
    b = 8'(8'h00 - sum);
    if (bad_ck) b = b + 8'h01;
    ok = !bad_ck;
    step_byte(b, gap_pct, 1'b0, 16'h0, 24'h0);
`else
    if (bad_ck) ok = 1'b1;
`endif
    chk("done_pulse", done, ok);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    chk("done_err", err, !ok);
    @(posedge clk);
    #1;
    chk("post_done", done, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_err", err, !ok);
    chk("post_wr_en", wr_en, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_addr = '0;
    last_data = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream, constant pixel.
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'hFF0080;
    send_frame(8'h03, 0, 1'b0);

    // Garbage before sync is dropped; sync value inside data is plain data.
    step_byte(8'h11, 0, 1'b0, 16'h0, 24'h0);
    chk("garbage_busy", busy, 0);
    step_byte(8'h22, 0, 1'b0, 16'h0, 24'h0);
    chk("garbage_busy", busy, 0);
    step_byte(8'h33, 0, 1'b0, 16'h0, 24'h0);
    chk("garbage_busy", busy, 0);
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'($urandom);
    frame_pix[5] = 24'hA5A5A5;
    send_frame(8'hA5, 0, 1'b0);

    // Same constant frame with random valid gaps.
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'hFF0080;
    send_frame(8'h03, 30, 1'b0);

    // Async reset in the middle of pixel data.
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'($urandom);
    step_byte(8'hA5, 0, 1'b0, 16'h0, 24'h0);
    step_byte(8'h42, 0, 1'b0, 16'h0, 24'h0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) begin
        step_byte(frame_pix[p][23 - 8 * k -: 8], 0, (k == 2), {8'h42, 8'(p)}, frame_pix[p]);
      end
    end
    step_byte(8'h5A, 0, 1'b0, 16'h0, 24'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    last_addr = '0;
    last_data = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h42, 10, 1'b0);

    // Top glyph index: last write lands at the top address with no wrap.
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'($urandom);
    send_frame(8'hFF, 5, 1'b0);
    chk("last_addr_top", wr_addr, 16'hFFFF);

`ifdef GLYPH_LOADER_CKSUM_EN
    for (int p = 0; p < Pix; p++) frame_pix[p] = 24'h010101;
    send_frame(8'h01, 0, 1'b0);
    send_frame(8'h01, 0, 1'b1);
    send_frame(8'h01, 5, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
